countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 13 +
 rtl/tick_gen.sv | 37 +++
 rtl/countdown_timer.sv | 129 ++++++++++++
 tb/tb_countdown_timer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encoding for the countdown timer and anything that decodes o_state.
package timer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap cycle.
module tick_gen #(
    parameter int unsigned PRESCALE = 25000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick is combinational so the owner can act on the same edge that wraps the counter.
    always_comb begin
        o_tick_c = i_enable && !i_clear && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause/resume, abort and a one-cycle expiry pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 25000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             done_q;
    logic             done_d;
    logic             presc_clr_c;
    logic             presc_en_c;
    logic             tick_c;

    // Prescaler parks at 0 outside RUN/PAUSED, so every fresh run starts phase-aligned;
    // PAUSED holds it for a lossless resume.
    assign presc_clr_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign presc_en_c  = (state_q == ST_RUN) && !i_pause && !i_abort;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (presc_clr_c),
        .i_enable  (presc_en_c),
        .o_tick_c  (tick_c)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_load) begin
                        count_d  = i_load_value;
                        reload_d = i_load_value;
                    end else if (i_start) begin
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick_c && (count_q != '0)) begin
                        count_d = count_q - WIDTH'(1);
                        if (count_q == WIDTH'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (i_start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (i_load) begin
                        count_d  = i_load_value;
                        reload_d = i_load_value;
                        state_d  = ST_IDLE;
                    end else if (i_start) begin
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end else begin
                            // Alternate so a held start never yields back-to-back pulses.
                            done_d = !done_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign o_count = count_q;
    assign o_done  = done_q;
    assign o_state = state_q;
    assign o_busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: PRESCALE=4 and PRESCALE=1 instances share stimulus and
// are compared every cycle against a cycle-count reference model.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int unsigned W = 8;
    localparam int S_IDLE   = int'(ST_IDLE);
    localparam int S_RUN    = int'(ST_RUN);
    localparam int S_PAUSED = int'(ST_PAUSED);
    localparam int S_DONE   = int'(ST_DONE);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort, load, start, pause;
    logic [W-1:0] lv;
    logic [W-1:0] cnt4, cnt1;
    logic         busy4, busy1, done4, done1;
    logic [1:0]   st4, st1;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state[2];
    int m_count[2];
    int m_reload[2];
    int m_phase[2];
    bit m_done[2];
    int m_p[2] = '{4, 1};

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .PRESCALE(4)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_load_value(lv),
        .i_start(start), .i_pause(pause), .i_abort(abort),
        .o_count(cnt4), .o_busy(busy4), .o_done(done4), .o_state(st4)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_load(load), .i_load_value(lv),
        .i_start(start), .i_pause(pause), .i_abort(abort),
        .o_count(cnt1), .o_busy(busy1), .o_done(done1), .o_state(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE; m_count[k] = 0; m_reload[k] = 0; m_phase[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    // One clock edge of timer behaviour: m_phase counts elapsed run cycles in the current period.
    task automatic model_step(input int k);
        bit prev;
        prev = m_done[k];
        m_done[k] = 1'b0;
        if (!rst_n) begin
            m_state[k] = S_IDLE; m_count[k] = 0; m_reload[k] = 0; m_phase[k] = 0;
        end else if (abort) begin
            m_state[k] = S_IDLE; m_count[k] = 0;
        end else begin
            case (m_state[k])
                S_IDLE: begin
                    if (load) begin
                        m_count[k] = int'(lv); m_reload[k] = int'(lv);
                    end else if (start) begin
                        if (m_count[k] != 0) begin
                            m_state[k] = S_RUN; m_phase[k] = 0;
                        end else begin
                            m_state[k] = S_DONE; m_done[k] = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        m_state[k] = S_PAUSED;
                    end else begin
                        m_phase[k]++;
                        if (m_phase[k] == m_p[k]) begin
                            m_phase[k] = 0;
                            m_count[k]--;
                            if (m_count[k] == 0) begin
                                m_state[k] = S_DONE; m_done[k] = 1'b1;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) m_state[k] = S_RUN;
                end
                default: begin
                    if (load) begin
                        m_count[k] = int'(lv); m_reload[k] = int'(lv); m_state[k] = S_IDLE;
                    end else if (start) begin
                        if (m_reload[k] != 0) begin
                            m_count[k] = m_reload[k]; m_state[k] = S_RUN; m_phase[k] = 0;
                        end else begin
                            m_done[k] = !prev;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("cnt_p4",  32'(cnt4),  32'(m_count[0]));
        check("st_p4",   32'(st4),   32'(m_state[0]));
        check("done_p4", 32'(done4), 32'(m_done[0]));
        check("busy_p4", 32'(busy4), 32'(m_state[0] == S_RUN || m_state[0] == S_PAUSED));
        check("cnt_p1",  32'(cnt1),  32'(m_count[1]));
        check("st_p1",   32'(st1),   32'(m_state[1]));
        check("done_p1", 32'(done1), 32'(m_done[1]));
        check("busy_p1", 32'(busy1), 32'(m_state[1] == S_RUN || m_state[1] == S_PAUSED));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic drive(input logic a, input logic l, input int v, input logic s, input logic p);
        abort = a; load = l; lv = W'(v); start = s; pause = p;
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_now_st",   32'(st4),   32'(S_IDLE));
        check("rst_now_cnt",  32'(cnt4),  32'd0);
        check("rst_now_done", 32'(done4), 32'd0);
        check("rst_now_busy", 32'(busy4), 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        check("reset_st",  32'(st4),  32'(S_IDLE));
        check("reset_cnt", 32'(cnt4), 32'd0);
        rst_n = 1'b1;

        // Basic run of 3
        drive(0, 1, 3, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        check("run_start_st",  32'(st4),  32'(S_RUN));
        check("run_start_cnt", 32'(cnt4), 32'd3);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("run_cnt",  32'(cnt4),  32'(3 - i / 4));
            check("run_done", 32'(done4), 32'(i == 12));
        end
        check("run_end_st",   32'(st4),   32'(S_DONE));
        check("run_end_busy", 32'(busy4), 32'd0);

        // Single-cycle prescale: load 5, expiry 5 cycles after start
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 1, 5, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        check("p1_start_cnt", 32'(cnt1), 32'd5);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check("p1_cnt",  32'(cnt1),  32'(5 - i));
            check("p1_done", 32'(done1), 32'(i == 5));
        end

        // Pause after 6 run cycles, hold 10, resume
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 1, 3, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check("pre_pause_cnt", 32'(cnt4), 32'(3 - i / 4));
        end
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("paused_st",  32'(st4),  32'(S_PAUSED));
            check("paused_cnt", 32'(cnt4), 32'd2);
        end
        drive(0, 0, 0, 1, 0); cycle();
        check("resume_st", 32'(st4), 32'(S_RUN));
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check("resume_cnt",  32'(cnt4),  32'((i < 2) ? 2 : (i < 6) ? 1 : 0));
            check("resume_done", 32'(done4), 32'(i == 6));
        end

        // Zero start, then held start must not produce back-to-back pulses
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 1, 0, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        check("zero_done", 32'(done4), 32'd1);
        check("zero_st",   32'(st4),   32'(S_DONE));
        check("zero_cnt",  32'(cnt4),  32'd0);
        cycle();
        check("zero_hold_done0", 32'(done4), 32'd0);
        cycle();
        check("zero_hold_done1", 32'(done4), 32'd1);
        drive(0, 0, 0, 0, 0); cycle();
        check("zero_rel_done", 32'(done4), 32'd0);

        // Abort+load+start together mid-run; reload survives the abort
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 1, 3, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0);
        repeat (5) cycle();
        drive(1, 1, 9, 1, 0); cycle();
        check("simul_st",   32'(st4),   32'(S_IDLE));
        check("simul_cnt",  32'(cnt4),  32'd0);
        check("simul_done", 32'(done4), 32'd0);
        drive(0, 0, 0, 1, 0); cycle();
        check("abort_zero_start_done", 32'(done4), 32'd1);
        cycle();
        check("done_restart_st",  32'(st4),  32'(S_RUN));
        check("done_restart_cnt", 32'(cnt4), 32'd3);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("rerun_done", 32'(done4), 32'(i == 12));
        end
        drive(0, 0, 0, 1, 0); cycle();
        check("rerun2_cnt", 32'(cnt4), 32'd3);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("rerun2_done", 32'(done4), 32'(i == 12));
        end

        // Reset mid-run discards the run
        drive(1, 0, 0, 0, 0); cycle();
        drive(0, 1, 5, 0, 0); cycle();
        drive(0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0);
        repeat (3) cycle();
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            cycle();
            check("post_rst_done", 32'(done4), 32'd0);
        end

        // Randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            abort = ($urandom_range(0, 39) == 0);
            load  = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 7) == 0);
            lv    = W'($urandom_range(0, 12));
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                drive(0, 0, 0, 0, 0);
                apply_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
